// File: rtl/vliw_div_pkg.sv
// Shared types and constants for the VLIW iterative divide resource.
package vliw_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   localparam int DIV_ITER  = 32;
   localparam int CNT_W     = $clog2(DIV_ITER);
   localparam int OP_REM    = 0;
   localparam int OP_SIGNED = 1;

endpackage

// File: rtl/div_core.sv
// Radix-2 restoring divider datapath: one quotient bit per cycle on unsigned magnitudes.
module div_core
   import vliw_div_pkg::*;
(
   input  logic        wb_clk_i,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] mag_a,
   input  logic [31:0] mag_b,
   output logic        last,
   output logic [31:0] quo,
   output logic [31:0] rem
);

   logic             active;
   logic [CNT_W-1:0] cnt;
   logic [63:0]      shreg;
   logic [63:0]      shreg_nxt;
   logic [31:0]      div_r;
   logic [32:0]      cand;
   logic [31:0]      diff;

   // Partial remainder after the shift needs 33 bits for the compare.
   always_comb begin
      cand = shreg[63:31];
      diff = cand[31:0] - div_r;
      if (cand >= {1'b0, div_r}) shreg_nxt = {diff, shreg[30:0], 1'b1};
      else                       shreg_nxt = {cand[31:0], shreg[30:0], 1'b0};
   end

   always_ff @(posedge wb_clk_i) begin
      if (rst || abort) begin
         active <= 1'b0;
         cnt    <= '0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= '0;
      end else if (active) begin
         cnt <= cnt + 1'b1;
         if (last) active <= 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (start) begin
         shreg <= {32'd0, mag_a};
         div_r <= mag_b;
      end else if (active) begin
         shreg <= shreg_nxt;
      end
   end

   assign last = active && (cnt == CNT_W'(DIV_ITER - 1));
   assign quo  = shreg[31:0];
   assign rem  = shreg[63:32];

endmodule

// File: rtl/div_scheduler.sv
// Round-robin arbiter, FSM and sign correction around the shared divider.
// Optional DIV_EARLY_OUT_EN: skip iterations when |b|==0 or |a|<|b|.
module div_scheduler
   import vliw_div_pkg::*;
#(
   parameter int NUM_REQ = 4
)
(
   input  logic                    wb_clk_i,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [2*NUM_REQ-1:0]    req_op,
   input  logic [32*NUM_REQ-1:0]   req_a,
   input  logic [32*NUM_REQ-1:0]   req_b,
   input  logic [NUM_REQ-1:0]      flush,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [NUM_REQ-1:0]      resp_valid,
   output logic [31:0]             resp_data,
   output logic [NUM_REQ-1:0]      busy
);

   localparam int IDX_W = $clog2(NUM_REQ);

   div_state_e        state, state_nxt;
   logic [IDX_W-1:0]  owner, rr_ptr, sel;
   logic              sel_vld, grant, skip;
   logic [NUM_REQ-1:0] eligible;
   logic [1:0]        lane_op;
   logic [31:0]       lane_a, lane_b, mag_a, mag_b;
   logic              sa, sb;
   logic              rem_sel, q_neg, r_neg, b_zero, skip_r;
   logic [31:0]       a_raw, core_quo, core_rem, result;
   logic              core_last, core_start, core_abort, resp_fire;

   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IDX_W'(s);
   endfunction

   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? -v : v;
   endfunction

   function automatic logic [31:0] sign_fix(input logic [31:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   assign eligible = req_valid & ~flush;

   // Lowest offset from rr_ptr wins; walking downward lets it overwrite last.
   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (eligible[rr_idx(rr_ptr, k)]) begin
            sel     = rr_idx(rr_ptr, k);
            sel_vld = 1'b1;
         end
      end
   end

   assign grant     = (state == IDLE) && sel_vld && !rst;
   assign req_ready = grant ? (NUM_REQ'(1) << sel) : '0;

   assign lane_op = req_op[2*int'(sel) +: 2];
   assign lane_a  = req_a[32*int'(sel) +: 32];
   assign lane_b  = req_b[32*int'(sel) +: 32];
   assign sa      = lane_op[OP_SIGNED] & lane_a[31];
   assign sb      = lane_op[OP_SIGNED] & lane_b[31];
   assign mag_a   = magnitude(lane_a, lane_op[OP_SIGNED]);
   assign mag_b   = magnitude(lane_b, lane_op[OP_SIGNED]);

`ifdef DIV_EARLY_OUT_EN
   assign skip = (mag_b == 32'd0) || (mag_a < mag_b);
`else
   assign skip = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant) state_nxt = skip ? DONE : RUN;
         RUN:     if (flush[owner]) state_nxt = IDLE;
                  else if (core_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (rst) begin
         state  <= IDLE;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            owner  <= sel;
            rr_ptr <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
         end
      end
   end

   // Operation attributes captured on the grant edge
   always_ff @(posedge wb_clk_i) begin
      if (grant) begin
         rem_sel <= lane_op[OP_REM];
         q_neg   <= sa ^ sb;
         r_neg   <= sa;
         b_zero  <= (lane_b == 32'd0);
         skip_r  <= skip;
         a_raw   <= lane_a;
      end
   end

   assign core_start = grant && !skip;
   assign core_abort = (state == RUN) && flush[owner];

   div_core u_core (
      .wb_clk_i (wb_clk_i),
      .rst      (rst),
      .start    (core_start),
      .abort    (core_abort),
      .mag_a    (mag_a),
      .mag_b    (mag_b),
      .last     (core_last),
      .quo      (core_quo),
      .rem      (core_rem)
   );

   // Divide-by-zero and early-out results bypass sign correction.
   always_comb begin
      if (b_zero)      result = rem_sel ? a_raw : 32'hFFFF_FFFF;
      else if (skip_r) result = rem_sel ? a_raw : 32'd0;
      else             result = rem_sel ? sign_fix(core_rem, r_neg) : sign_fix(core_quo, q_neg);
   end

   assign resp_fire  = (state == DONE) && !flush[owner];
   assign resp_valid = resp_fire ? (NUM_REQ'(1) << owner) : '0;
   assign resp_data  = resp_fire ? result : 32'd0;
   assign busy       = req_valid & ~resp_valid;

endmodule

// File: tb/tb_div_scheduler.sv
// Randomized and directed bench for div_scheduler against a transaction-level reference.
module tb_div_scheduler;

   localparam int N = 4;
`ifdef DIV_EARLY_OUT_EN
   localparam int LAT_SHORT = 1;
`else
   localparam int LAT_SHORT = 33;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid, flush;
   logic [2*N-1:0]    req_op;
   logic [32*N-1:0]   req_a, req_b;
   logic [N-1:0]      req_ready, resp_valid, busy;
   logic [31:0]       resp_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   div_scheduler #(.NUM_REQ(N)) dut (
      .wb_clk_i   (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .flush      (flush),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference arithmetic: 64-bit integer division, truncating toward zero.
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
      if (op[1]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return op[0] ? r[31:0] : q[31:0];
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
      logic [31:0] ma, mb;
      ma = (op[1] && a[31]) ? -a : a;
      mb = (op[1] && b[31]) ? -b : b;
      if (b == 32'd0 || ma < mb) return 1;
`endif
      if (op == 2'b11 && a == 32'd1 && b == 32'd0) return 33;
      return 33;
   endfunction

   // Transaction-level model: owner, cycles left until the result, rr pointer.
   bit          m_act = 0;
   int          m_left = 0;
   int          m_own = 0;
   int          m_rr = 0;
   logic [31:0] m_res = 0;

   always @(negedge clk) begin
      logic [N-1:0] e_rdy, e_rsp;
      logic [31:0]  e_dat;
      int           g;
      e_rdy = '0;
      e_rsp = '0;
      e_dat = '0;
      g     = -1;
      if (m_act && m_left == 0) begin
         if (!flush[m_own]) begin
            e_rsp[m_own] = 1'b1;
            e_dat        = m_res;
         end
         m_act = 0;
      end else if (m_act) begin
         if (flush[m_own]) m_act = 0;
         else m_left--;
      end else begin
         for (int k = 0; k < N; k++) begin
            automatic int i;
            i = (m_rr + k) % N;
            if (g < 0 && req_valid[i] && !flush[i]) g = i;
         end
         if (g >= 0 && !rst) begin
            e_rdy[g] = 1'b1;
            m_own    = g;
            m_rr     = (g + 1) % N;
            m_res    = ref_div(req_op[2*g +: 2], req_a[32*g +: 32], req_b[32*g +: 32]);
            m_left   = ref_lat(req_op[2*g +: 2], req_a[32*g +: 32], req_b[32*g +: 32]) - 1;
            m_act    = 1;
         end
      end
      if (rst) begin
         m_act = 0;
         m_rr  = 0;
      end
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("resp_valid", 32'(resp_valid), 32'(e_rsp));
      chk("resp_data", resp_data, e_dat);
      chk("busy", 32'(busy), 32'(req_valid & ~e_rsp));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_lane(input int lane, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[2*lane +: 2]  = op;
      req_a[32*lane +: 32] = a;
      req_b[32*lane +: 32] = b;
      req_valid[lane]      = 1'b1;
   endtask

   task automatic lit_op(input string name, input int lane, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expd, input int explat);
      int tg, tr;
      logic [31:0] d;
      tg = -1;
      tr = -1;
      d  = '0;
      set_lane(lane, op, a, b);
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (tg < 0 && req_ready[lane]) tg = cyc;
         if (resp_valid[lane]) begin
            tr = cyc;
            d  = resp_data;
         end
         tick();
         if (tr >= 0) break;
      end
      req_valid[lane] = 1'b0;
      if (tr < 0 || tg < 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no grant/response within bound (grant=%0d resp=%0d)", name, tg, tr);
      end else begin
         chk({name, "_data"}, d, expd);
         chk({name, "_lat"}, 32'(tr - tg), 32'(explat));
      end
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom % 6)
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom % 16);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int gt[N];
      bit dn[N];
      int t0, t1, r0cnt;
      logic [N-1:0] rv;

      rst = 1'b1; req_valid = '0; flush = '0; req_op = '0; req_a = '0; req_b = '0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      tick();
      rst = 1'b0;

      lit_op("u100d7_q", 0, 2'b00, 32'd100, 32'd7, 32'd14, 33);
      lit_op("u100d7_r", 0, 2'b01, 32'd100, 32'd7, 32'd2, 33);
      lit_op("sm7d2_q", 2, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      lit_op("sm7d2_r", 2, 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      lit_op("dz_q", 1, 2'b00, 32'h1234, 32'd0, 32'hFFFF_FFFF, LAT_SHORT);
      lit_op("dz_r", 1, 2'b01, 32'h1234, 32'd0, 32'h1234, LAT_SHORT);
      lit_op("ovf_q", 3, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
      lit_op("ovf_r", 3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
      lit_op("u3d10_q", 0, 2'b00, 32'd3, 32'd10, 32'd0, LAT_SHORT);
      lit_op("u3d10_r", 0, 2'b01, 32'd3, 32'd10, 32'd3, LAT_SHORT);

      // Four simultaneous requests from a fresh round-robin pointer.
      pulse_reset();
      for (int i = 0; i < N; i++) begin
         gt[i] = -1;
         dn[i] = 0;
         set_lane(i, 2'(i % 2), $urandom | 32'h8000_0000, 32'd1 + ($urandom % 1000));
      end
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (req_ready[i] && gt[i] < 0) gt[i] = cyc;
            if (resp_valid[i]) dn[i] = 1;
         end
         tick();
         for (int i = 0; i < N; i++) if (dn[i]) req_valid[i] = 1'b0;
         if (req_valid == '0) break;
      end
      if (req_valid != '0) begin
         checks++;
         errors++;
         $display("FAIL rr4_timeout: pending lanes %b", req_valid);
         req_valid = '0;
      end
      for (int i = 1; i < N; i++) chk("rr4_grant_offset", 32'(gt[i] - gt[0]), 32'(34 * i));

      // Owner flush mid-run hands the divider to the waiting lane at once.
      pulse_reset();
      set_lane(0, 2'b00, 32'hDEAD_BEEF, 32'd3);
      set_lane(1, 2'b01, 32'd1000, 32'd7);
      t0 = -1;
      for (int k = 0; k < 5 && t0 < 0; k++) begin
         @(negedge clk);
         if (req_ready[0]) t0 = cyc;
         tick();
      end
      repeat (9) tick();
      flush[0] = 1'b1;
      req_valid[0] = 1'b0;
      tick();
      flush[0] = 1'b0;
      @(negedge clk);
      chk("flush_regrant", 32'(req_ready), 32'b0010);
      chk("flush_regrant_cycle", 32'(cyc - t0), 32'd11);
      r0cnt = 0;
      t1 = -1;
      tick();
      for (int k = 0; k < 50 && t1 < 0; k++) begin
         @(negedge clk);
         if (resp_valid[0]) r0cnt++;
         if (resp_valid[1]) t1 = cyc;
         tick();
      end
      req_valid = '0;
      chk("flush_no_resp0", 32'(r0cnt), 32'd0);
      chk("flush_lane1_done", 32'(t1 >= 0), 32'd1);

      // Reset in the middle of an operation.
      set_lane(2, 2'b10, 32'h7FFF_0000, 32'hFFFF_FF00);
      repeat (5) tick();
      rst = 1'b1;
      req_valid = '0;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_resp_data", resp_data, 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      tick();

      // Randomized traffic with occasional flushes and resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rv = resp_valid;
         tick();
         rst = ($urandom % 800 == 0);
         for (int i = 0; i < N; i++) begin
            if (flush[i]) begin
               flush[i]     = 1'b0;
               req_valid[i] = 1'b0;
            end else if (rv[i]) begin
               req_valid[i] = 1'b0;
            end else if (req_valid[i] && ($urandom % 100 == 0)) begin
               flush[i] = 1'b1;
            end else if (!req_valid[i] && ($urandom % 4 == 0)) begin
               set_lane(i, 2'($urandom % 4), rnd_operand(), rnd_operand());
            end
         end
      end
      rst = 1'b0;
      req_valid = '0;
      flush = '0;
      repeat (40) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
